// File: rtl/keypad_emulator_if.sv
// Keypad scan lines and key-press command port shared between the emulator
// (slave) and whatever drives the scanner side and issues commands (master).
interface keypad_emulator_if;
    logic [3:0] col;
    logic [3:0] fila;
    logic [3:0] key_idx;
    logic       key_valid;
    logic       key_ready;
    logic       contact;
    logic       done;
    logic [7:0] scan_hits;

    modport master (
        output col,
        output key_idx,
        output key_valid,
        input  fila,
        input  key_ready,
        input  contact,
        input  done,
        input  scan_hits
    );

    modport slave (
        input  col,
        input  key_idx,
        input  key_valid,
        output fila,
        output key_ready,
        output contact,
        output done,
        output scan_hits
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model: answers scanner column strobes on the row lines while
// an emulated key is held, with contact bounce at press and release.
module keypad_emulator #(
    parameter int BOUNCE_PERIOD = 2,
    parameter int BOUNCE_EDGES  = 4,
    parameter int HOLD_CYCLES   = 64,
    parameter int GAP_CYCLES    = 32
) (
    input  logic               clk,
    input  logic               reset,
    keypad_emulator_if.slave   kp
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    localparam logic [31:0] PERIOD_LAST = 32'(BOUNCE_PERIOD - 1);
    localparam logic [31:0] SEG_LAST    = 32'(BOUNCE_EDGES);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [31:0] seg_r, seg_s;
    logic [1:0]  key_row_r, key_col_r;
    logic [3:0]  col_r;
    logic        contact_r, contact_s;
    logic        ready_r, ready_s;
    logic        done_r, done_s;
    logic [7:0]  hits_r, hits_s;
    logic        accept_s;
    logic        col_fall_s;
    logic [3:0]  fila_s;

    // Next-state and phase counters; cnt counts cycles within a segment or phase.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + 32'd1;
        seg_s    = seg_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 32'd0;
                seg_s = 32'd0;
                if (kp.key_valid && ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_BOUNCE_IN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BOUNCE_IN: begin
                if (cnt_r == PERIOD_LAST) begin
                    cnt_s = 32'd0;
                    if (seg_r == SEG_LAST) begin
                        seg_s   = 32'd0;
                        state_s = ST_HOLD;
                    end else begin
                        seg_s   = seg_r + 32'd1;
                    end
                end else begin
                    state_s = ST_BOUNCE_IN;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_s   = 32'd0;
                    state_s = ST_BOUNCE_OUT;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_BOUNCE_OUT: begin
                if (cnt_r == PERIOD_LAST) begin
                    cnt_s = 32'd0;
                    if (seg_r == SEG_LAST) begin
                        seg_s   = 32'd0;
                        state_s = ST_GAP;
                    end else begin
                        seg_s   = seg_r + 32'd1;
                    end
                end else begin
                    state_s = ST_BOUNCE_OUT;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s   = 32'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 32'd0;
                seg_s   = 32'd0;
            end
        endcase
    end

    // Output values for the coming cycle, so contact/ready/done leave flops.
    always_comb begin
        contact_s = 1'b0;
        case (state_s)
            ST_BOUNCE_IN:  contact_s = ~seg_s[0];
            ST_HOLD:       contact_s = 1'b1;
            ST_BOUNCE_OUT: contact_s = seg_s[0];
            default:       contact_s = 1'b0;
        endcase
        ready_s = (state_s == ST_IDLE);
        done_s  = (state_s == ST_GAP) && (cnt_s == GAP_LAST);
    end

    // Scan hit counter: falling strobe on the key's column while held.
    always_comb begin
        col_fall_s = col_r[key_col_r] & ~kp.col[key_col_r];
        if (accept_s) begin
            hits_s = 8'd0;
        end else if ((state_r == ST_HOLD) && col_fall_s && (hits_r != 8'hFF)) begin
            hits_s = hits_r + 8'd1;
        end else begin
            hits_s = hits_r;
        end
    end

    // Row drive: combinational from live col so scanner sees zero latency.
    always_comb begin
        fila_s = 4'b1111;
        if (contact_r && !kp.col[key_col_r]) begin
            fila_s[key_row_r] = 1'b0;
        end else begin
            fila_s = 4'b1111;
        end
    end

    // State, latched key and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 32'd0;
            seg_r     <= 32'd0;
            contact_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            hits_r    <= 8'd0;
            key_row_r <= 2'd0;
            key_col_r <= 2'd0;
            col_r     <= 4'b1111;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            seg_r     <= seg_s;
            contact_r <= contact_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            hits_r    <= hits_s;
            col_r     <= kp.col;
            if (accept_s) begin
                key_row_r <= kp.key_idx[3:2];
                key_col_r <= kp.key_idx[1:0];
            end
        end
    end

    assign kp.fila      = fila_s;
    assign kp.key_ready = ready_r;
    assign kp.contact   = contact_r;
    assign kp.done      = done_r;
    assign kp.scan_hits = hits_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: two instances (default timing and a
// long bounce-free hold) checked every cycle against a timeline model.
module tb_keypad_emulator;

    localparam int BP  = 2;
    localparam int GAP = 32;
    localparam int E0  = 4;
    localparam int H0  = 64;
    localparam int E1  = 0;
    localparam int H1  = 600;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_emulator_if kp0();
    keypad_emulator_if kp1();

    logic [3:0] col_d[2];
    logic [3:0] kidx_d[2];
    logic       kval_d[2];
    logic [3:0] fila_o[2];
    logic       ready_o[2];
    logic       contact_o[2];
    logic       done_o[2];
    logic [7:0] hits_o[2];

    assign kp0.col = col_d[0];
    assign kp0.key_idx = kidx_d[0];
    assign kp0.key_valid = kval_d[0];
    assign kp1.col = col_d[1];
    assign kp1.key_idx = kidx_d[1];
    assign kp1.key_valid = kval_d[1];
    assign fila_o[0] = kp0.fila;
    assign fila_o[1] = kp1.fila;
    assign ready_o[0] = kp0.key_ready;
    assign ready_o[1] = kp1.key_ready;
    assign contact_o[0] = kp0.contact;
    assign contact_o[1] = kp1.contact;
    assign done_o[0] = kp0.done;
    assign done_o[1] = kp1.done;
    assign hits_o[0] = kp0.scan_hits;
    assign hits_o[1] = kp1.scan_hits;

    keypad_emulator #(.BOUNCE_PERIOD(BP), .BOUNCE_EDGES(E0), .HOLD_CYCLES(H0), .GAP_CYCLES(GAP))
        dut0 (.clk(clk), .reset(reset), .kp(kp0));
    keypad_emulator #(.BOUNCE_PERIOD(BP), .BOUNCE_EDGES(E1), .HOLD_CYCLES(H1), .GAP_CYCLES(GAP))
        dut1 (.clk(clk), .reset(reset), .kp(kp1));

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: position n in the press timeline (n=1 is the cycle after acceptance).
    bit         m_busy[2];
    int         m_n[2];
    logic [3:0] m_key[2];
    logic [3:0] m_pcol[2];
    int         m_hits[2];

    int         mode[2];
    logic [3:0] hold_col[2];
    int         tog[2];

    function automatic int f_e(input int id);
        return (id == 0) ? E0 : E1;
    endfunction

    function automatic int f_h(input int id);
        return (id == 0) ? H0 : H1;
    endfunction

    function automatic int f_b(input int id);
        return (f_e(id) + 1) * BP;
    endfunction

    function automatic int f_total(input int id);
        return 2 * f_b(id) + f_h(id) + GAP;
    endfunction

    function automatic bit f_in_hold(input int id, input int n);
        return (n > f_b(id)) && (n <= f_b(id) + f_h(id));
    endfunction

    function automatic bit f_contact(input int id, input int n);
        int b, h;
        b = f_b(id);
        h = f_h(id);
        if (n <= b) return (((n - 1) / BP) % 2) == 0;
        if (n <= b + h) return 1'b1;
        if (n <= 2 * b + h) return (((n - b - h - 1) / BP) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset(input int id);
        m_busy[id] = 1'b0;
        m_n[id]    = 0;
        m_key[id]  = 4'd0;
        m_pcol[id] = 4'b1111;
        m_hits[id] = 0;
    endtask

    task automatic model_edge(input int id);
        int c;
        if (reset) return;
        c = int'(m_key[id][1:0]);
        if (m_busy[id]) begin
            if (f_in_hold(id, m_n[id]) && m_pcol[id][c] && !col_d[id][c] && m_hits[id] < 255)
                m_hits[id]++;
            if (m_n[id] == f_total(id)) m_busy[id] = 1'b0;
            else m_n[id]++;
        end else if (kval_d[id]) begin
            m_busy[id] = 1'b1;
            m_n[id]    = 1;
            m_key[id]  = kidx_d[id];
            m_hits[id] = 0;
        end
        m_pcol[id] = col_d[id];
    endtask

    task automatic check_dut(input int id);
        logic [3:0] ef;
        bit ec;
        int c, r;
        c  = int'(m_key[id][1:0]);
        r  = int'(m_key[id][3:2]);
        ec = m_busy[id] && f_contact(id, m_n[id]);
        ef = 4'b1111;
        if (ec && !col_d[id][c]) ef[r] = 1'b0;
        chk_val($sformatf("fila%0d", id), {28'd0, fila_o[id]}, {28'd0, ef});
        chk_val($sformatf("contact%0d", id), {31'd0, contact_o[id]}, {31'd0, ec});
        chk_val($sformatf("ready%0d", id), {31'd0, ready_o[id]}, {31'd0, !m_busy[id]});
        chk_val($sformatf("done%0d", id), {31'd0, done_o[id]},
                {31'd0, m_busy[id] && (m_n[id] == f_total(id))});
        chk_val($sformatf("hits%0d", id), {24'd0, hits_o[id]}, 32'(m_hits[id]));
    endtask

    task automatic drive_cols();
        logic [3:0] one;
        one = 4'b0001;
        for (int id = 0; id < 2; id++) begin
            case (mode[id])
                0: col_d[id] = hold_col[id];
                1: col_d[id] = ~(one << ((cyc / 4) % 4));
                2: col_d[id] = col_d[id] ^ (one << tog[id]);
                3: col_d[id] = 4'($urandom);
                default: col_d[id] = hold_col[id];
            endcase
        end
    endtask

    task automatic step();
        drive_cols();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        cyc++;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        reset = 1'b1;
        for (int id = 0; id < 2; id++) begin
            col_d[id]    = 4'b1111;
            kidx_d[id]   = 4'd0;
            kval_d[id]   = 1'b0;
            mode[id]     = 0;
            hold_col[id] = 4'b1111;
            tog[id]      = 0;
            model_reset(id);
        end
        repeat (2) step();
        reset = 1'b0;

        // Idle with rotating strobes: rows must stay released.
        mode[0] = 1;
        mode[1] = 1;
        repeat (32) step();

        // Key 6 with col held at 1011.
        mode[1] = 3;
        mode[0] = 0;
        hold_col[0] = 4'b1011;
        kidx_d[0] = 4'b0110;
        kval_d[0] = 1'b1;
        step();
        kval_d[0] = 1'b0;
        repeat (120) step();

        // Same key with rotating one-hot-low strobes.
        mode[0] = 1;
        kval_d[0] = 1'b1;
        step();
        kval_d[0] = 1'b0;
        repeat (120) step();

        // Long hold without bounce, column toggled every cycle: counter saturates.
        mode[0] = 3;
        kidx_d[1] = 4'($urandom);
        tog[1] = int'(kidx_d[1][1:0]);
        col_d[1] = 4'b1111;
        mode[1] = 2;
        kval_d[1] = 1'b1;
        step();
        kval_d[1] = 1'b0;
        repeat (640) step();
        chk_val("hits_sat", {24'd0, hits_o[1]}, 32'd255);

        // Command port ignored mid-sequence, then reset at k+40.
        mode[1] = 3;
        mode[0] = 0;
        hold_col[0] = 4'b1011;
        kidx_d[0] = 4'b0110;
        kval_d[0] = 1'b1;
        step();
        kval_d[0] = 1'b0;
        repeat (19) step();
        kidx_d[0] = 4'hF;
        kval_d[0] = 1'b1;
        repeat (3) step();
        kval_d[0] = 1'b0;
        repeat (17) step();
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_dut(0);
        check_dut(1);
        step();
        reset = 1'b0;
        mode[0] = 3;
        kval_d[0] = 1'b1;
        step();
        kval_d[0] = 1'b0;
        repeat (120) step();

        // Back-to-back commands with key_valid held high.
        kidx_d[0] = 4'h0;
        kval_d[0] = 1'b1;
        step();
        kidx_d[0] = 4'hF;
        repeat (117) step();
        kval_d[0] = 1'b0;
        repeat (120) step();

        // Random commands and strobes on both instances.
        for (int i = 0; i < 1500; i++) begin
            kval_d[0] = ($urandom_range(7) == 0);
            kval_d[1] = ($urandom_range(7) == 0);
            kidx_d[0] = 4'($urandom);
            kidx_d[1] = 4'($urandom);
            step();
        end
        kval_d[0] = 1'b0;
        kval_d[1] = 1'b0;
        repeat (700) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural-synthesizable 4x4 matrix keypad model, the responding end of the keypad scan interface. It watches the column strobes driven by the keypad scanner (`Driver_teclado`) and pulls the matching row line low while an emulated key is pressed, including contact bounce at press and release. A simple valid/ready command port queues one key press at a time. It lets the scanner, `Memoria_RGB` and the FSM be exercised on the bench and in on-board self-test without a physical keypad.

## Interface
- `BOUNCE_PERIOD`, 2: clock cycles per bounce segment; must be ≥1.
- `BOUNCE_EDGES`, 4: extra contact toggles at press and at release; must be even, 0 allowed.
- `HOLD_CYCLES`, 64: clock cycles of stable contact; must be ≥1.
- `GAP_CYCLES`, 32: clock cycles of stable release after the release bounce; must be ≥1.

- `clk`  in  1  single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `col`  in  4  column strobes from the scanner, active-low (selected column = 0).
- `fila`  out  4  row lines to the scanner, active-low, idle 4'b1111.
- `key_idx`  in  4  key to press: row = key_idx[3:2], column = key_idx[1:0].
- `key_valid`  in  1  command request.
- `key_ready`  out  1  high only in IDLE.
- `contact`  out  1  current emulated contact state (1 = closed).
- `done`  out  1  one-cycle pulse at end of a press sequence.
- `scan_hits`  out  8  count of column selections seen during HOLD, saturating.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- Reset values: state IDLE, contact 0, fila 4'b1111, key_ready 1, done 0, scan_hits 0, latched key 0, registered col 4'b1111.
- IDLE: key_ready=1, contact=0. Command accepted on a rising edge with key_valid && key_ready; key_idx latched, scan_hits cleared, → BOUNCE_IN.
- BOUNCE_IN: (BOUNCE_EDGES+1) segments of BOUNCE_PERIOD cycles each; segment i (from 0) has contact = 1 for even i, 0 for odd i. It therefore starts and ends closed. Then → HOLD.
- HOLD: contact=1 for HOLD_CYCLES cycles, then → BOUNCE_OUT.
- BOUNCE_OUT: same segment count and length as BOUNCE_IN; contact = 1 for odd i, 0 for even i. It starts and ends open. Then → GAP.
- GAP: contact=0 for GAP_CYCLES cycles; done=1 in the last GAP cycle, then → IDLE.
- fila is combinational from the registered contact, the latched key and the live col:
  - fila[r] = 0 iff contact=1 and col[c]=0.
  - All other bits are 1.
  - Multiple low col bits are legal; only col[c] matters.
- scan_hits:
  - Register col each cycle.
  - Increment when state=HOLD and col[c] falls 1→0 (registered col[c]=1, live col[c]=0).
  - Saturates at 255; holds its value until the next command is accepted.
- key_valid and key_idx are ignored outside IDLE; a changing key_idx during a sequence has no effect.
- Reset asserted mid-sequence: immediate return to the reset values, including fila=4'b1111 asynchronously. No done pulse is produced.

## Timing
- Let edge k accept the command; "cycle k+n" is the n-th cycle after that edge. B = (BOUNCE_EDGES+1)·BOUNCE_PERIOD.
- Cycles k+1 … k+B: BOUNCE_IN. Cycles k+B+1 … k+B+HOLD_CYCLES: HOLD. The next B cycles: BOUNCE_OUT. Then GAP_CYCLES cycles of GAP.
- Defaults (B=10): BOUNCE_IN k+1..k+10, HOLD k+11..k+74, BOUNCE_OUT k+75..k+84, GAP k+85..k+116. done=1 in cycle k+116; key_ready=1 from cycle k+117.
- Earliest next acceptance is at the edge ending cycle k+117. Back-to-back commands are allowed with key_valid held high.
- col → fila is zero-latency combinational; contact → fila changes in the same cycle contact changes.
- key_ready is low from cycle k+1 until IDLE re-entry.

## Test plan
- Reset, then idle with col cycling 1110→1101→1011→0111 every 4 cycles: fila stays 4'b1111; key_ready=1; done never pulses.
- Defaults, key_idx=4'b0110 (row 1, col 2) accepted at edge k, col held at 4'b1011:
  - contact pattern 11 00 11 00 11 over k+1..k+10; fila=4'b1101 whenever contact=1, else 4'b1111.
  - stable through k+74; release bounce 00 11 00 11 00 over k+75..k+84.
  - done only at k+116; ready at k+117.
- Same key with col rotating one-hot-low every 4 cycles: fila[1] is low only while col[2]=0 during HOLD; scan_hits=4 at done (64/16).
- BOUNCE_EDGES=0, HOLD_CYCLES=600, col toggling col[c] every cycle: no bounce, contact clean; scan_hits saturates at 255.
- key_idx changed to 4'hF and key_valid pulsed during HOLD: no effect on fila or timing. Reset asserted at k+40: fila=4'b1111 and key_ready=1 immediately, no done. A new command after reset runs the full sequence.
- key_valid held high with keys 4'h0 then 4'hF: the second is accepted at the edge ending k+117; fila[3] responds to col[3] only.
